// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register: main feeds the output, skid absorbs
// the one extra word that can arrive in the cycle a stall is first seen.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Encodings equal the number of held words so count is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             consume;

    // Ready depends only on flops and rst, so chained stages see no ready ripple.
    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign count     = state;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus a scoreboarded random handshake run for pipe_skid_reg.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [1:0]  exp_count;
        logic        exp_in_ready;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model_q[$];

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A stalled output word must not change until it is taken.
    property p_stable_on_stall;
        @(posedge clk) disable iff (rst || flush)
            (out_valid && !out_ready) |=> $stable(out_data);
    endproperty
    a_stable_on_stall: assert property (p_stable_on_stall)
        else begin
            $display("[TB] FAIL stall_stability: out_data changed to %h while stalled", out_data);
            n_fail++;
        end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic r, input logic f, input logic iv, input logic [31:0] d,
                           input logic ordy, input logic ov, input logic [31:0] od,
                           input logic [1:0] cnt, input logic ir);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_out_valid = ov; v.exp_out_data = od; v.exp_count = cnt; v.exp_in_ready = ir;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst       = v.rst;
        flush     = v.flush;
        in_valid  = v.in_valid;
        in_data   = v.in_data;
        out_ready = v.out_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        string tag;
        int    drain_budget;
        logic [31:0] next_word;
        logic  acc;
        logic  con;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // rst flush iv data ordy | ov data cnt in_ready
        add_vec(1, 0, 0, 32'h00, 0,  0, 32'h00, 0, 0);
        add_vec(1, 0, 1, 32'h55, 1,  0, 32'h00, 0, 0);
        add_vec(0, 0, 0, 32'h00, 0,  0, 32'h00, 0, 1);
        add_vec(0, 0, 1, 32'h01, 1,  1, 32'h01, 1, 1);
        add_vec(0, 0, 1, 32'h02, 1,  1, 32'h02, 1, 1);
        add_vec(0, 0, 1, 32'h03, 1,  1, 32'h03, 1, 1);
        add_vec(0, 0, 1, 32'h04, 1,  1, 32'h04, 1, 1);
        add_vec(0, 0, 0, 32'h00, 1,  0, 32'h04, 0, 1);
        add_vec(0, 0, 1, 32'h0A, 0,  1, 32'h0A, 1, 1);
        add_vec(0, 0, 1, 32'h0B, 0,  1, 32'h0A, 2, 0);
        add_vec(0, 0, 1, 32'h0C, 0,  1, 32'h0A, 2, 0);
        add_vec(0, 0, 1, 32'h0C, 1,  1, 32'h0B, 1, 1);
        add_vec(0, 0, 1, 32'h0C, 1,  1, 32'h0C, 1, 1);
        add_vec(0, 0, 0, 32'h00, 1,  0, 32'h0C, 0, 1);
        add_vec(0, 0, 1, 32'h05, 0,  1, 32'h05, 1, 1);
        add_vec(0, 0, 1, 32'h06, 1,  1, 32'h06, 1, 1);
        add_vec(0, 0, 0, 32'h00, 1,  0, 32'h06, 0, 1);
        add_vec(0, 0, 1, 32'h07, 0,  1, 32'h07, 1, 1);
        add_vec(0, 0, 1, 32'h08, 0,  1, 32'h07, 2, 0);
        add_vec(0, 1, 1, 32'h09, 1,  0, 32'h07, 0, 1);
        add_vec(0, 0, 0, 32'h00, 1,  0, 32'h07, 0, 1);
        add_vec(0, 0, 1, 32'h11, 0,  1, 32'h11, 1, 1);
        add_vec(0, 0, 1, 32'h22, 0,  1, 32'h11, 2, 0);
        add_vec(1, 1, 1, 32'h33, 1,  0, 32'h00, 0, 0);
        add_vec(0, 0, 0, 32'h00, 0,  0, 32'h00, 0, 1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            tag = $sformatf("vec%0d", i);
            check_output({tag, "_out_valid"}, 32'(out_valid), 32'(vecs[i].exp_out_valid));
            check_output({tag, "_out_data"},  out_data,       vecs[i].exp_out_data);
            check_output({tag, "_count"},     32'(count),     32'(vecs[i].exp_count));
            check_output({tag, "_in_ready"},  32'(in_ready),  32'(vecs[i].exp_in_ready));
        end

        // Random handshakes against a two-deep FIFO model; DUT starts EMPTY here.
        next_word = 32'h1000;
        for (int c = 0; c < 300; c++) begin
            rst       = 1'b0;
            flush     = 1'b0;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = next_word;
            out_ready = ($urandom_range(0, 2) != 0);
            check_output("rand_in_ready",  32'(in_ready),  32'(model_q.size() < 2));
            check_output("rand_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            check_output("rand_count",     32'(count),     32'(model_q.size()));
            if (model_q.size() > 0)
                check_output("rand_out_data", out_data, model_q[0]);
            acc = in_valid && (model_q.size() < 2);
            con = out_ready && (model_q.size() > 0);
            @(posedge clk);
            #1;
            if (con) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(next_word);
                next_word = next_word + 32'd1;
            end
        end

        // Drain whatever is left, bounded so a stuck output cannot hang the run.
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        drain_budget = 8;
        while (model_q.size() > 0 && drain_budget > 0) begin
            check_output("drain_out_data", out_data, model_q[0]);
            @(posedge clk);
            #1;
            if (out_valid || model_q.size() > 0) void'(model_q.pop_front());
            drain_budget--;
        end
        check_output("drain_done", 32'(model_q.size()), 32'd0);
        check_output("drain_empty_valid", 32'(out_valid), 32'd0);
        check_output("drain_empty_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry valid/ready pipeline register ("skid buffer") for inter-stage links in the core. It is the handshake-aware receiving end of a plain pipeline flop. It accepts a word from the upstream stage and holds it until the downstream stage takes it, so a stalled consumer back-pressures the producer without losing data. The register sustains one transfer per cycle and has no combinational path from `out_ready` to `in_ready`, which lets stages be chained without long ready chains.

## Interface
- `WIDTH`, default 32: payload width in bits.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; discards all held words.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream takes the word this cycle.
- `out_data`  out  WIDTH  payload of the oldest held word.
- `count`  out  2  number of held words, 0..2.

## Operation
- Storage is two registers:
  - `main` drives `out_data`.
  - `skid` holds the overflow word.
- State is derived from the valid bits: EMPTY (0 words), ONE (main valid), TWO (main and skid valid). `count` = 0/1/2 accordingly.
- Transfer rules:
  - accept = `in_valid & in_ready`.
  - consume = `out_valid & out_ready`.
- `out_valid` = main valid, registered.
- `in_ready` = `!rst & (state != TWO)`. It is a function of flops and `rst` only, never of `out_ready`.
- Transitions, evaluated when not in reset and not flushing:
  - EMPTY: accept -> `main <= in_data`, go to ONE. Otherwise stay.
  - ONE, accept & consume: `main <= in_data`, stay in ONE.
  - ONE, accept & !consume: `skid <= in_data`, go to TWO.
  - ONE, !accept & consume: go to EMPTY.
  - ONE, neither: hold.
  - TWO, consume: `main <= skid`, go to ONE. No accept is possible because `in_ready` is 0.
  - TWO, !consume: hold both words.
- Ordering: words leave in arrival order. No word is duplicated or dropped except by `flush`/`rst`.
- `flush` has priority over all transfers:
  - Next state is EMPTY.
  - An accept or consume signalled in the flush cycle has no effect on state.
  - The data registers keep their stale contents; only the valid bits clear.
- `rst` has priority over `flush`:
  - State goes to EMPTY.
  - `main` and `skid` are cleared to 0.
- Data registers load only on the listed transitions. Otherwise they hold.

## Timing
- Reset values, after the first rising edge with `rst`=1:
  - `out_valid`=0, `out_data`=0, `count`=0.
  - `in_ready`=1 once `rst` deasserts. `in_ready` is 0 while `rst`=1.
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: with `out_ready` held at 1, one word per cycle indefinitely. `in_ready` stays 1 and the skid buffer is never used.
- Stall: if `out_ready` drops, at most one further word is absorbed into `skid`. `in_ready` falls the cycle after that accept.
- Release from TWO: `in_ready` returns to 1 the cycle after the consume.
- Mid-operation reset or flush with words held: the held words are gone the next cycle. The source must re-present any word it still needs.
- `out_data` is stable while `out_valid & !out_ready`. Verification asserts this.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release. Required: `out_valid`=0, `out_data`=0, `count`=0 during reset and after. `in_ready`=0 while `rst`=1, then 1.
- **Streaming:** drive 0x1, 0x2, 0x3, 0x4 on consecutive cycles with `out_ready`=1. Required: the output shows the same sequence, each one cycle after its input, with `count`=1 throughout and `in_ready` constantly 1.
- **Back-pressure:**
  - With `out_ready`=0, offer 0xA, 0xB, 0xC. Required: 0xA and 0xB are accepted, `count`=2, `in_ready`=0, and 0xC is held by the source.
  - Then raise `out_ready`. Required: output 0xA, 0xB, 0xC in order with none lost.
- **Simultaneous accept and consume in ONE:** `main`=0x5 with `in_valid`=1, data 0x6, and `out_ready`=1. Required: next cycle `out_data`=0x6, `count`=1, and `skid` unused.
- **Flush:** in TWO (0x7, 0x8), assert `flush` together with `out_ready`=1 and `in_valid`=1. Required: next cycle `count`=0, `out_valid`=0, `in_ready`=1, and neither word appears later.
- **Reset mid-stall:** in TWO, assert `rst` together with `flush`. Required: EMPTY state and `out_data`=0 after the edge.
